// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared fetch-unit state encodings, opcodes and widths
package riscv_defs;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// rtl/instruction_fetch_unit_pc_register.sv - program counter with load and +4 increment
module pc_register #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Load wins over increment so a redirect overrides the sequential step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with redirect and stale-drop
module instruction_fetch_unit
  import riscv_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] Instruction,
  output logic [6:0]         Opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_misaligned
);

  logic [2:0]        state, state_nxt;
  logic              drop, drop_nxt;
  logic [ADDR_W-1:0] pc;
  logic              target_aligned;
  logic              in_flight;
  logic              capture;

  assign target_aligned = is_word_aligned(redirect_pc[1:0]);

  // A response is still owed by memory after this edge: it must be swallowed
  // before any request at the new PC goes out.
  assign in_flight = (state == ST_REQ  && imem_req_ready)
                   || (state == ST_WAIT && !imem_resp_valid)
                   || (state == ST_ERR  && drop && !imem_resp_valid);

  assign capture = (state == ST_WAIT) && imem_resp_valid && !drop && !redirect_valid;

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    if (redirect_valid) begin
      drop_nxt = in_flight;
      if (!target_aligned) begin
        state_nxt = ST_ERR;
      end else begin
        state_nxt = in_flight ? ST_WAIT : ST_REQ;
      end
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_REQ;
        ST_REQ:  if (imem_req_ready) state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = ST_REQ;
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: if (instr_ready) state_nxt = ST_REQ;
        ST_ERR:  if (drop && imem_resp_valid) drop_nxt = 1'b0;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      drop             <= 1'b0;
      Instruction      <= '0;
      instr_pc         <= '0;
      fetch_misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        Instruction <= imem_resp_data;
        instr_pc    <= pc;
      end
      if (redirect_valid) begin
        fetch_misaligned <= !target_aligned;
      end
    end
  end

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .inc     ((state == ST_HOLD) && instr_ready),
    .pc      (pc)
  );

  assign imem_req_valid = (state == ST_REQ);
  assign imem_addr      = pc;
  assign instr_valid    = (state == ST_HOLD);
  assign Opcode         = Instruction[6:0];

endmodule
